fifo_thr: RTL and testbench

FIFO_THR -- requirements
Module: fifo_thr

---
 rtl/fifo_thr.sv | 141 ++++++++++++++
 tb/tb_fifo_thr.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_thr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_thr
// Purpose  : Single-clock FIFO with programmable almost-full/almost-empty
//            thresholds, sticky overflow/underflow flags, synchronous flush
//            and a selectable read mode (first-word-fall-through or
//            registered read). Depth need not be a power of two.
// Ports    : clk, rst (async, active-high)
//            flush            - synchronous clear of contents
//            wdata, wr        - write side; full/afull status
//            rdata, rd, rvalid- read side; empty/aempty status
//            usedw            - stored word count (0..FIFO_DEPTH)
//            ovf, udf         - sticky error flags; clr_err clears them
// Revision : 1.0 - initial release
// ============================================================================
module fifo_thr #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 128,
  parameter int AFULL_LVL  = FIFO_DEPTH - 8,
  parameter int AEMPTY_LVL = 8,
  parameter int FWFT       = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic                              wr,
  output logic                              full,
  output logic                              afull,
  output logic [DATA_WIDTH-1:0]             rdata,
  input  logic                              rd,
  output logic                              rvalid,
  output logic                              empty,
  output logic                              aempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   usedw,
  output logic                              ovf,
  output logic                              udf,
  input  logic                              clr_err
);

  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPT_CNT = CW'(AEMPTY_LVL);

  // Stop elaboration on illegal parameter combinations.
  if ((DATA_WIDTH < 1) || (FIFO_DEPTH < 2) ||
      (AFULL_LVL < 1) || (AFULL_LVL > FIFO_DEPTH) ||
      (AEMPTY_LVL < 0) || (AEMPTY_LVL > FIFO_DEPTH - 1) ||
      ((FWFT != 0) && (FWFT != 1))) begin : g_param_fail
    $fatal(1, "fifo_thr: illegal parameter combination");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic [CW-1:0]         count;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the pre-edge flags; flush blocks both sides.
  assign wr_acc = wr && !full  && !flush;
  assign rd_acc = rd && !empty && !flush;

  // Status is decoded straight from the count register so all flags move
  // together with usedw.
  assign usedw  = count;
  assign full   = (count == DEPTH_CNT);
  assign empty  = (count == '0);
  assign afull  = (count >= AFULL_CNT);
  assign aempty = (count <= AEMPT_CNT);

  // Pointers and count. Wrap is an explicit compare so non-power-of-two
  // depths work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wp <= (wp == LAST_ADDR) ? '0 : wp + 1'b1;
      if (rd_acc) rp <= (rp == LAST_ADDR) ? '0 : rp + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage: no reset, written only on accepted writes.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp] <= wdata;
  end

  // Sticky error flags. A new error event wins over a simultaneous clear.
  // Flush cycles neither set nor clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr && full && !flush)       ovf <= 1'b1;
      else if (clr_err)               ovf <= 1'b0;
      if (rd && empty && !flush)      udf <= 1'b1;
      else if (clr_err)               udf <= 1'b0;
    end
  end

  if (FWFT == 1) begin : g_fwft
    // Head word is always presented; a read simply advances the pointer.
    assign rdata  = mem[rp];
    assign rvalid = !empty;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    // rdata holds its last value between reads; rvalid pulses for the
    // single cycle following an accepted read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem[rp];
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_thr.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_thr
// Purpose  : Directed self-checking bench for fifo_thr. Two instances with
//            DATA_WIDTH=8, FIFO_DEPTH=5, AFULL_LVL=4, AEMPTY_LVL=1: "a" in
//            first-word-fall-through mode and "b" in registered-read mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_thr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_flush = 0, a_wr = 0, a_rd = 0, a_clr = 0;
  logic [7:0] a_wdata = '0;
  logic [7:0] a_rdata;
  logic       a_full, a_afull, a_rvalid, a_empty, a_aempty, a_ovf, a_udf;
  logic [2:0] a_usedw;

  logic       b_flush = 0, b_wr = 0, b_rd = 0, b_clr = 0;
  logic [7:0] b_wdata = '0;
  logic [7:0] b_rdata;
  logic       b_full, b_afull, b_rvalid, b_empty, b_aempty, b_ovf, b_udf;
  logic [2:0] b_usedw;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_thr #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AFULL_LVL(4), .AEMPTY_LVL(1),
             .FWFT(1)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .wdata(a_wdata), .wr(a_wr),
    .full(a_full), .afull(a_afull), .rdata(a_rdata), .rd(a_rd),
    .rvalid(a_rvalid), .empty(a_empty), .aempty(a_aempty), .usedw(a_usedw),
    .ovf(a_ovf), .udf(a_udf), .clr_err(a_clr)
  );

  fifo_thr #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AFULL_LVL(4), .AEMPTY_LVL(1),
             .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .wdata(b_wdata), .wr(b_wr),
    .full(b_full), .afull(b_afull), .rdata(b_rdata), .rd(b_rd),
    .rvalid(b_rvalid), .empty(b_empty), .aempty(b_aempty), .usedw(b_usedw),
    .ovf(b_ovf), .udf(b_udf), .clr_err(b_clr)
  );

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if ({a_usedw, a_empty, a_full, a_afull, a_aempty, a_ovf, a_udf, a_rvalid}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: usedw=%0d e=%b f=%b af=%b ae=%b ovf=%b udf=%b rv=%b, expected 0 1 0 0 1 0 0 0",
               a_usedw, a_empty, a_full, a_afull, a_aempty, a_ovf, a_udf, a_rvalid);
    end
    n_checks++;
    if ({b_usedw, b_empty, b_rvalid, b_rdata} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_b: usedw=%0d empty=%b rvalid=%b rdata=%h, expected 0 1 0 00",
               b_usedw, b_empty, b_rvalid, b_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      a_wdata = 8'(8'h11 + i);
      a_wr    = 1'b1;
      tick();
      n_checks++;
      if (a_usedw !== 3'(i + 1) || a_aempty !== (i + 1 <= 1) ||
          a_afull !== (i + 1 >= 4) || a_full !== (i + 1 == 5) || a_empty !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: usedw=%0d ae=%b af=%b f=%b e=%b, expected usedw=%0d ae=%b af=%b f=%b e=0",
                 i, a_usedw, a_aempty, a_afull, a_full, a_empty,
                 i + 1, (i + 1 <= 1), (i + 1 >= 4), (i + 1 == 5));
      end
      if (i == 0) begin
        n_checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 8'h11) begin
          n_fail++;
          $display("FAIL fwft_first: rvalid=%b rdata=%h, expected 1 11", a_rvalid, a_rdata);
        end
      end
    end
    a_wdata = 8'h16;
    tick();
    a_wr = 1'b0;
    n_checks++;
    if (a_usedw !== 3'd5 || a_ovf !== 1'b1 || a_full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: usedw=%0d ovf=%b full=%b, expected 5 1 1", a_usedw, a_ovf, a_full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (a_rdata !== 8'(8'h11 + i) || a_rvalid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_%0d: rdata=%h rvalid=%b, expected %h 1", i, a_rdata, a_rvalid, 8'(8'h11 + i));
      end
      a_rd = 1'b1;
      tick();
      n_checks++;
      if (a_usedw !== 3'(4 - i)) begin
        n_fail++;
        $display("FAIL drain_cnt_%0d: usedw=%0d, expected %0d", i, a_usedw, 4 - i);
      end
    end
    a_rd = 1'b0;
    n_checks++;
    if (a_empty !== 1'b1 || a_rvalid !== 1'b0 || a_udf !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: empty=%b rvalid=%b udf=%b, expected 1 0 0", a_empty, a_rvalid, a_udf);
    end
    a_rd = 1'b1;
    tick();
    a_rd = 1'b0;
    n_checks++;
    if (a_udf !== 1'b1 || a_usedw !== 3'd0 || a_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: udf=%b usedw=%0d ovf=%b, expected 1 0 1", a_udf, a_usedw, a_ovf);
    end
  endtask

  task automatic test_flush();
    a_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_wdata = 8'(8'h40 + i);
      tick();
    end
    a_flush = 1'b1;
    a_wdata = 8'h77;
    tick();
    a_flush = 1'b0;
    a_wr    = 1'b0;
    n_checks++;
    if (a_usedw !== 3'd0 || a_empty !== 1'b1 || a_rvalid !== 1'b0 ||
        a_ovf !== 1'b1 || a_udf !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: usedw=%0d empty=%b rvalid=%b ovf=%b udf=%b, expected 0 1 0 1 1",
               a_usedw, a_empty, a_rvalid, a_ovf, a_udf);
    end
    // Next write lands at address 0 and is the new head.
    a_wr    = 1'b1;
    a_wdata = 8'h99;
    tick();
    a_wr = 1'b0;
    n_checks++;
    if (a_rdata !== 8'h99 || a_usedw !== 3'd1) begin
      n_fail++;
      $display("FAIL post_flush: rdata=%h usedw=%0d, expected 99 1", a_rdata, a_usedw);
    end
  endtask

  task automatic test_clr_err();
    a_rd = 1'b1;
    tick();
    // Empty now: underflow event together with clr_err keeps udf set.
    a_clr = 1'b1;
    tick();
    a_rd = 1'b0;
    n_checks++;
    if (a_ovf !== 1'b0 || a_udf !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: ovf=%b udf=%b, expected 0 1", a_ovf, a_udf);
    end
    tick();
    a_clr = 1'b0;
    n_checks++;
    if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: ovf=%b udf=%b, expected 0 0", a_ovf, a_udf);
    end
  endtask

  task automatic test_registered_read();
    b_wr    = 1'b1;
    b_wdata = 8'hA5;
    tick();
    b_wr = 1'b0;
    n_checks++;
    if (b_rvalid !== 1'b0 || b_usedw !== 3'd1 || b_rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL regrd_write: rvalid=%b usedw=%0d rdata=%h, expected 0 1 00", b_rvalid, b_usedw, b_rdata);
    end
    b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    n_checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 8'hA5 || b_usedw !== 3'd0) begin
      n_fail++;
      $display("FAIL regrd_data: rvalid=%b rdata=%h usedw=%0d, expected 1 a5 0", b_rvalid, b_rdata, b_usedw);
    end
    tick();
    n_checks++;
    if (b_rvalid !== 1'b0 || b_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL regrd_hold: rvalid=%b rdata=%h, expected 0 a5", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] wnext;
    logic [7:0] rnext;
    wnext = 8'h30;
    rnext = 8'h30;
    a_wr  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_wdata = wnext;
      wnext++;
      tick();
    end
    a_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_wdata = wnext;
      wnext++;
      n_checks++;
      if (a_rdata !== rnext) begin
        n_fail++;
        $display("FAIL wrap_data_%0d: rdata=%h, expected %h", i, a_rdata, rnext);
      end
      rnext++;
      tick();
      n_checks++;
      if (a_usedw !== 3'd2) begin
        n_fail++;
        $display("FAIL wrap_cnt_%0d: usedw=%0d, expected 2", i, a_usedw);
      end
    end
    a_rd = 1'b0;
    // Fill to full, then simultaneous wr/rd: read wins, write dropped.
    for (int i = 0; i < 3; i++) begin
      a_wdata = wnext;
      wnext++;
      tick();
    end
    a_rd    = 1'b1;
    a_wdata = 8'hEE;
    tick();
    a_wr = 1'b0;
    a_rd = 1'b0;
    n_checks++;
    if (a_usedw !== 3'd4 || a_ovf !== 1'b1 || a_rdata !== 8'(rnext + 1)) begin
      n_fail++;
      $display("FAIL full_wr_rd: usedw=%0d ovf=%b rdata=%h, expected 4 1 %h",
               a_usedw, a_ovf, a_rdata, 8'(rnext + 1));
    end
    a_flush = 1'b1;
    a_clr   = 1'b1;
    tick();
    a_flush = 1'b0;
    a_clr   = 1'b0;
    // Empty: simultaneous wr/rd writes and flags underflow.
    a_wr    = 1'b1;
    a_rd    = 1'b1;
    a_wdata = 8'h3C;
    tick();
    a_wr = 1'b0;
    a_rd = 1'b0;
    n_checks++;
    if (a_usedw !== 3'd1 || a_udf !== 1'b1 || a_ovf !== 1'b0 || a_rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL empty_wr_rd: usedw=%0d udf=%b ovf=%b rdata=%h, expected 1 1 0 3c",
               a_usedw, a_udf, a_ovf, a_rdata);
    end
  endtask

  task automatic test_async_reset();
    a_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_wdata = 8'(8'h60 + i);
      tick();
    end
    a_wr = 1'b0;
    b_wr = 1'b1;
    b_wdata = 8'h5C;
    tick();
    b_wr = 1'b0;
    b_rd = 1'b1;
    tick();
    b_rd = 1'b0;
    // a now holds 4 words; b has a registered rdata of 5C.
    n_checks++;
    if (a_usedw !== 3'd4 || b_rdata !== 8'h5C || a_udf !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_rst: a_usedw=%0d b_rdata=%h a_udf=%b, expected 4 5c 1", a_usedw, b_rdata, a_udf);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_usedw, a_empty, a_full, a_afull, a_aempty, a_ovf, a_udf, a_rvalid}
        !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_rst_a: usedw=%0d e=%b f=%b af=%b ae=%b ovf=%b udf=%b rv=%b, expected 0 1 0 0 1 0 0 0",
               a_usedw, a_empty, a_full, a_afull, a_aempty, a_ovf, a_udf, a_rvalid);
    end
    n_checks++;
    if (b_rdata !== 8'h00 || b_rvalid !== 1'b0 || b_usedw !== 3'd0) begin
      n_fail++;
      $display("FAIL async_rst_b: rdata=%h rvalid=%b usedw=%0d, expected 00 0 0", b_rdata, b_rvalid, b_usedw);
    end
    tick();
    rst = 1'b0;
    a_wr    = 1'b1;
    a_wdata = 8'h5A;
    tick();
    a_wr = 1'b0;
    n_checks++;
    if (a_rdata !== 8'h5A || a_usedw !== 3'd1) begin
      n_fail++;
      $display("FAIL post_rst: rdata=%h usedw=%0d, expected 5a 1", a_rdata, a_usedw);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_flush();
    test_clr_err();
    test_registered_read();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
